fft_butterfly_sequencer: RTL and testbench
==========================================

Name: fft_butterfly_sequencer

Overview:
- Initiator side of the butterfly handshake: owns an N-point complex sample buffer and walks it through all radix-2 DIT stages in place.
- Per butterfly: presents operand pair plus twiddle index, toggles new_input flag, waits for ready, writes both results back.
- Sits between the sample-capture front end (load port) and the spectrum consumer (read port); drives one external butterfly_unit.

Parameters:
- LOG2_N, 5, log2 of transform size; N=32, twiddle index 4 bits.
- DATA_W, 16, component width; equals data_size+1 from parameters.v.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- load_valid  in  1  write one sample (ignored while busy)
- load_index  in  LOG2_N  natural-order sample index
- load_re  in  DATA_W  sample real
- load_im  in  DATA_W  sample imag
- start  in  1  begin transform (ignored while busy)
- busy  out  1  transform in progress
- done  out  1  one-cycle pulse on completion
- rd_addr  in  LOG2_N  bin index
- rd_re  out  DATA_W  bin real, registered, 1-cycle latency
- rd_im  out  DATA_W  bin imag, registered, 1-cycle latency
- bf_ra, bf_ca, bf_rb, bf_cb  out  DATA_W each  operands A, B (real/imag) to butterfly
- bf_twiddle_num  out  LOG2_N-1  twiddle index
- bf_new_input_flag  out  1  toggles once per issued butterfly
- bf_o_ra, bf_o_ca, bf_o_rb, bf_o_cb  in  DATA_W each  butterfly results
- bf_ready_flag  in  1  butterfly ready level

Behaviour:
- Reset (async): busy=0, done=0, rd_re/rd_im=0, all bf_* outputs=0, bf_new_input_flag=0, buffer cleared to 0, FSM=IDLE.
- Load: in IDLE, load_valid writes {load_re, load_im} to buffer[bitrev(load_index)] at the clock edge.
- Simultaneous load_valid and start in IDLE: the write lands first; start is accepted the same edge.
- Iteration: stage s=0..LOG2_N-1, k=0..N/2-1.
  - h=2^s, j=k mod h, g=k>>s.
  - a=(g<<(s+1))|j, b=a+h.
  - bf_twiddle_num = j<<(LOG2_N-1-s).
  - 80 butterflies for N=32.
- FSM:
  - IDLE: start -> ISSUE; busy rises on the same edge.
  - ISSUE (1 cycle): register buffer[a] to bf_ra/bf_ca, buffer[b] to bf_rb/bf_cb, twiddle to bf_twiddle_num; toggle bf_new_input_flag; clear armed; -> WAIT.
  - WAIT: set armed when bf_ready_flag==0. When armed && bf_ready_flag==1 -> WRITE. A stale high ready left over from the previous butterfly is never accepted.
  - WRITE (1 cycle): buffer[a] <= {bf_o_ra, bf_o_ca}; buffer[b] <= {bf_o_rb, bf_o_cb}. Advance k/s. -> ISSUE, or DONE after the last butterfly.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- All bf_* operand outputs are held constant from ISSUE through WRITE; the butterfly reads them directly in its final stage.
- No timeout: WAIT holds indefinitely.
- Arithmetic: results are written as-is, wrapping two's complement. No saturation.
- Read port: valid any time; during busy it returns intermediate data.
- Reset mid-run: immediate return to reset state; no done pulse. Shares rst with butterfly_unit so both flags restart at 0.

Optional Feature:
- Macro FFT_SEQ_STAGE_SCALE_EN.
- Defined: each of the four results is arithmetic-shifted right by 1 before WRITE (sign preserved), giving an overall 1/N scaling.
- Undefined: results are written unmodified.

Decomposition:
- Shared include parameters.v: data_size, LOG2_N, FSM state encodings.
- One natural sub-module: fft_addr_gen, combinational from (s, k) to (a, b, twiddle_num) plus last flags.
- Buffer is a register array inside the top module.

Test Plan:
- Reset asserted mid-WAIT -> busy=0, done=0, bf_new_input_flag=0, all outputs 0; a restart then completes 80 butterflies.
- Stub butterfly (rb'=ra-rb, ra'=ra+rb, ready after 4 cycles); x[0]=0x0200, others 0 -> bins 0..31 all re=0x0200, im=0.
- Same stub; all x=0x0200 -> bin0 re=0x4000, others 0. With FFT_SEQ_STAGE_SCALE_EN -> bin0 re=0x0200.
- Stub holds ready high from before the toggle and then low 10 cycles -> no writeback until the rising edge; bf_ra..bf_cb stable throughout; exactly one toggle per butterfly, 80 toggles total.
- Monitor bf_twiddle_num -> stage0 all 0; stage4 sequence 0..15; stage2 sequence 0,4,8,12 repeated.
- Integration with butterfly_unit: x[1]=0x4000 -> |bin k| ≈ 0x4000 within ±4 LSB per component; done pulses exactly once.

Source files
------------

// File: rtl/fft_butterfly_sequencer_pkg.sv
// Shared defaults, sequencer state encoding and the bit-reverse helper for the
// FFT butterfly sequencer.
package fft_butterfly_sequencer_pkg;

  localparam int DEF_LOG2_N = 5;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // Reverses the low 'width' bits of value; upper bits of the result are zero.
  function automatic logic [15:0] bit_reverse(input logic [15:0] value, input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly_sequencer_addr_gen.sv
// Radix-2 DIT in-place address generator: maps (stage, butterfly index) to the
// operand pair, twiddle index and end-of-stage / end-of-transform flags.
module fft_butterfly_sequencer_addr_gen #(
  parameter int LOG2_N  = 5,
  parameter int STAGE_W = 3
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [LOG2_N-2:0]  k,
  output logic [LOG2_N-1:0]  addr_a,
  output logic [LOG2_N-1:0]  addr_b,
  output logic [LOG2_N-2:0]  twiddle_num,
  output logic               last_k,
  output logic               last_stage
);

  logic [LOG2_N-1:0]  k_ext;
  logic [LOG2_N-1:0]  half_span;
  logic [LOG2_N-1:0]  j_off;
  logic [LOG2_N-1:0]  group;
  logic [LOG2_N-1:0]  tw_full;
  logic [STAGE_W-1:0] tw_shift;

  always_comb begin
    k_ext     = {1'b0, k};
    half_span = LOG2_N'(1) << stage;
    j_off     = k_ext & (half_span - LOG2_N'(1));
    group     = k_ext >> stage;
    // bit 'stage' of addr_a is always zero, so OR-ing in half_span is a+h
    addr_a    = (group << (stage + STAGE_W'(1))) | j_off;
    addr_b    = addr_a | half_span;
    tw_shift  = STAGE_W'(LOG2_N - 1) - stage;
    tw_full   = j_off << tw_shift;
    twiddle_num = tw_full[LOG2_N-2:0];
    last_k      = (k == '1);
    last_stage  = (stage == STAGE_W'(LOG2_N - 1));
  end

endmodule

// File: rtl/fft_butterfly_sequencer.sv
// In-place radix-2 DIT FFT sequencer driving one external butterfly unit.
// Build option FFT_SEQ_STAGE_SCALE_EN: halve every butterfly result (1/N overall).
//
// state    | meaning
// IDLE     | accept loads (bit-reversed placement) and start
// ISSUE    | register operands/twiddle, toggle new_input flag
// WAIT     | wait for ready to fall, then rise again
// WRITE    | store both results, advance butterfly/stage
// DONE     | one-cycle done pulse
module fft_butterfly_sequencer
  import fft_butterfly_sequencer_pkg::*;
#(
  parameter int LOG2_N = DEF_LOG2_N,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [LOG2_N-1:0] load_index,
  input  logic [DATA_W-1:0] load_re,
  input  logic [DATA_W-1:0] load_im,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [LOG2_N-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_re,
  output logic [DATA_W-1:0] rd_im,
  output logic [DATA_W-1:0] bf_ra,
  output logic [DATA_W-1:0] bf_ca,
  output logic [DATA_W-1:0] bf_rb,
  output logic [DATA_W-1:0] bf_cb,
  output logic [LOG2_N-2:0] bf_twiddle_num,
  output logic              bf_new_input_flag,
  input  logic [DATA_W-1:0] bf_o_ra,
  input  logic [DATA_W-1:0] bf_o_ca,
  input  logic [DATA_W-1:0] bf_o_rb,
  input  logic [DATA_W-1:0] bf_o_cb,
  input  logic              bf_ready_flag
);

  localparam int N       = 1 << LOG2_N;
  localparam int TW_W    = LOG2_N - 1;
  localparam int STAGE_W = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;

  logic [DATA_W-1:0] buf_re [N];
  logic [DATA_W-1:0] buf_im [N];

  seq_state_e        state;
  logic [STAGE_W-1:0] stage;
  logic [TW_W-1:0]   k;
  logic              armed;

  logic [LOG2_N-1:0] addr_a;
  logic [LOG2_N-1:0] addr_b;
  logic [TW_W-1:0]   twiddle_num;
  logic              last_k;
  logic              last_stage;
  logic [LOG2_N-1:0] load_addr;

  logic [DATA_W-1:0] wr_ra;
  logic [DATA_W-1:0] wr_ca;
  logic [DATA_W-1:0] wr_rb;
  logic [DATA_W-1:0] wr_cb;

  fft_butterfly_sequencer_addr_gen #(
    .LOG2_N  (LOG2_N),
    .STAGE_W (STAGE_W)
  ) u_addr_gen (
    .stage       (stage),
    .k           (k),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .twiddle_num (twiddle_num),
    .last_k      (last_k),
    .last_stage  (last_stage)
  );

  assign load_addr = LOG2_N'(bit_reverse(16'(load_index), LOG2_N));

  always_comb begin
`ifdef FFT_SEQ_STAGE_SCALE_EN
    wr_ra = $signed(bf_o_ra) >>> 1;
    wr_ca = $signed(bf_o_ca) >>> 1;
    wr_rb = $signed(bf_o_rb) >>> 1;
    wr_cb = $signed(bf_o_cb) >>> 1;
`else
    wr_ra = bf_o_ra;
    wr_ca = bf_o_ca;
    wr_rb = bf_o_rb;
    wr_cb = bf_o_cb;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      stage             <= '0;
      k                 <= '0;
      armed             <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      bf_ra             <= '0;
      bf_ca             <= '0;
      bf_rb             <= '0;
      bf_cb             <= '0;
      bf_twiddle_num    <= '0;
      bf_new_input_flag <= 1'b0;
      for (int i = 0; i < N; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            buf_re[load_addr] <= load_re;
            buf_im[load_addr] <= load_im;
          end
          if (start) begin
            state <= ST_ISSUE;
            busy  <= 1'b1;
            stage <= '0;
            k     <= '0;
          end
        end
        ST_ISSUE: begin
          bf_ra             <= buf_re[addr_a];
          bf_ca             <= buf_im[addr_a];
          bf_rb             <= buf_re[addr_b];
          bf_cb             <= buf_im[addr_b];
          bf_twiddle_num    <= twiddle_num;
          bf_new_input_flag <= ~bf_new_input_flag;
          armed             <= 1'b0;
          state             <= ST_WAIT;
        end
        ST_WAIT: begin
          // ready must be seen low first so a level left over from the
          // previous butterfly is never mistaken for this one's result
          if (!bf_ready_flag) armed <= 1'b1;
          else if (armed)     state <= ST_WRITE;
        end
        ST_WRITE: begin
          buf_re[addr_a] <= wr_ra;
          buf_im[addr_a] <= wr_ca;
          buf_re[addr_b] <= wr_rb;
          buf_im[addr_b] <= wr_cb;
          if (last_k) begin
            k <= '0;
            if (last_stage) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              stage <= stage + STAGE_W'(1);
              state <= ST_ISSUE;
            end
          end else begin
            k     <= k + TW_W'(1);
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_re <= '0;
      rd_im <= '0;
    end else begin
      rd_re <= buf_re[rd_addr];
      rd_im <= buf_im[rd_addr];
    end
  end

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Self-checking bench: stub butterfly (sum/difference, optional twiddle mix) and
// an independent in-place FFT reference model over the whole sample buffer.
module tb_fft_butterfly_sequencer;

  localparam int LOG2_N = 5;
  localparam int N      = 32;
  localparam int DW     = 16;
`ifdef FFT_SEQ_STAGE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [4:0]    load_index = '0;
  logic [DW-1:0] load_re = '0, load_im = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [4:0]    rd_addr = '0;
  logic [DW-1:0] rd_re, rd_im;
  logic [DW-1:0] bf_ra, bf_ca, bf_rb, bf_cb;
  logic [3:0]    bf_twiddle_num;
  logic          bf_new_input_flag;
  logic [DW-1:0] bf_o_ra, bf_o_ca, bf_o_rb, bf_o_cb;
  logic          bf_ready_flag;

  always #5 clk = ~clk;

  fft_butterfly_sequencer dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_index(load_index),
    .load_re(load_re), .load_im(load_im), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_re(rd_re), .rd_im(rd_im),
    .bf_ra(bf_ra), .bf_ca(bf_ca), .bf_rb(bf_rb), .bf_cb(bf_cb),
    .bf_twiddle_num(bf_twiddle_num), .bf_new_input_flag(bf_new_input_flag),
    .bf_o_ra(bf_o_ra), .bf_o_ca(bf_o_ca), .bf_o_rb(bf_o_rb), .bf_o_cb(bf_o_cb),
    .bf_ready_flag(bf_ready_flag)
  );

  int errors = 0;
  int checks = 0;

  // stub configuration, set by the test tasks
  int hold_hi = 0;
  int lat     = 4;
  bit tw_mix  = 1'b0;

  logic          stub_prev;
  int            hi_cnt, lo_cnt;
  bit            stub_active;
  logic [DW-1:0] l_ra, l_ca, l_rb, l_cb;
  logic [3:0]    l_tw;
  int            tw_log[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_prev <= 1'b0; stub_active <= 1'b0; bf_ready_flag <= 1'b0;
      hi_cnt <= 0; lo_cnt <= 0;
      bf_o_ra <= '0; bf_o_ca <= '0; bf_o_rb <= '0; bf_o_cb <= '0;
    end else begin
      stub_prev <= bf_new_input_flag;
      if (bf_new_input_flag != stub_prev) begin
        l_ra <= bf_ra; l_ca <= bf_ca; l_rb <= bf_rb; l_cb <= bf_cb; l_tw <= bf_twiddle_num;
        tw_log.push_back(int'(bf_twiddle_num));
        hi_cnt <= hold_hi; lo_cnt <= lat; stub_active <= 1'b1;
      end else if (stub_active) begin
        if (hi_cnt != 0) hi_cnt <= hi_cnt - 1;
        else if (lo_cnt != 0) begin bf_ready_flag <= 1'b0; lo_cnt <= lo_cnt - 1; end
        else begin
          bf_o_ra <= l_ra + l_rb;
          bf_o_ca <= l_ca + l_cb + (tw_mix ? {12'd0, l_tw} : 16'd0);
          bf_o_rb <= l_ra - l_rb;
          bf_o_cb <= l_ca - l_cb;
          bf_ready_flag <= 1'b1;
          stub_active <= 1'b0;
        end
      end
    end
  end

  // negedge monitor: toggles, operand changes without a toggle, done pulses
  int            toggles = 0, stab_err = 0, done_cnt = 0;
  logic          mon_flag = 1'b0;
  logic [67:0]   mon_ops = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bf_new_input_flag !== mon_flag) toggles++;
      else if ({bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle_num} !== mon_ops) stab_err++;
      if (done === 1'b1) done_cnt++;
    end
    mon_flag = bf_new_input_flag;
    mon_ops  = {bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle_num};
  end

  logic [DW-1:0] in_re [N];
  logic [DW-1:0] in_im [N];
  logic [DW-1:0] exp_re [N];
  logic [DW-1:0] exp_im [N];

  function automatic int rev5(input int v);
    int r = 0;
    for (int i = 0; i < LOG2_N; i++) if (v[i]) r |= 1 << (LOG2_N - 1 - i);
    return r;
  endfunction

  // classic size-doubling in-place FFT with the stub's arithmetic
  task automatic model_fft(input bit mix);
    logic signed [DW-1:0] mr [N];
    logic signed [DW-1:0] mi [N];
    logic signed [DW-1:0] nra, nca, nrb, ncb;
    int m, half, p, q, tw;
    for (int i = 0; i < N; i++) begin mr[rev5(i)] = in_re[i]; mi[rev5(i)] = in_im[i]; end
    for (m = 2; m <= N; m = m * 2) begin
      half = m / 2;
      for (int base = 0; base < N; base += m) begin
        for (int j = 0; j < half; j++) begin
          p = base + j; q = p + half; tw = j * (N / m);
          nra = mr[p] + mr[q];
          nca = mi[p] + mi[q] + (mix ? 16'(tw) : 16'd0);
          nrb = mr[p] - mr[q];
          ncb = mi[p] - mi[q];
          if (SCALE) begin nra = nra >>> 1; nca = nca >>> 1; nrb = nrb >>> 1; ncb = ncb >>> 1; end
          mr[p] = nra; mi[p] = nca; mr[q] = nrb; mi[q] = ncb;
        end
      end
    end
    for (int i = 0; i < N; i++) begin exp_re[i] = mr[i]; exp_im[i] = mi[i]; end
  endtask

  task automatic do_reset();
    rst = 1'b1; load_valid = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // loads in a scrambled order; the final sample shares its cycle with start
  task automatic load_and_start(input int mul, input int add);
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (i * mul + add) % N;
      load_valid = 1'b1; load_index = 5'(idx);
      load_re = in_re[idx]; load_im = in_im[idx];
      start = (i == N - 1);
      @(posedge clk); #1;
    end
    load_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit noisy);
    int cyc = 0;
    bit seen = 1'b0;
    while (cyc < 20000 && !seen) begin
      if (noisy && cyc < 20) begin
        load_valid = 1'b1; load_index = 5'($urandom); start = 1'b1;
        load_re = 16'($urandom); load_im = 16'($urandom);
      end else begin
        load_valid = 1'b0; start = 1'b0;
      end
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    load_valid = 1'b0; start = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL %s done_timeout: no done after %0d cycles", name, cyc); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic run_and_check(input string name, input bit noisy, input bit mix);
    int t0, d0;
    t0 = toggles; d0 = done_cnt;
    tw_mix = mix;
    model_fft(mix);
    load_and_start(7, 3);
    wait_done(name, noisy);
    checks++;
    if (toggles - t0 != 80) begin errors++; $display("FAIL %s toggles: got %0d expected 80", name, toggles - t0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after: got %b expected 0", name, busy); end
    for (int a = 0; a < N; a++) begin
      rd_addr = 5'(a);
      @(posedge clk); #1;
      checks++;
      if (rd_re !== exp_re[a] || rd_im !== exp_im[a]) begin
        errors++;
        $display("FAIL %s bin%0d: got %h/%h expected %h/%h", name, a, rd_re, rd_im, exp_re[a], exp_im[a]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_status: got busy=%b done=%b expected 0", busy, done); end
    checks++;
    if ({bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle_num, bf_new_input_flag} !== 69'd0) begin
      errors++; $display("FAIL reset_bf_outputs: got %h %h %h %h tw=%h flag=%b expected all 0",
                        bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle_num, bf_new_input_flag);
    end
    checks++;
    if ({rd_re, rd_im} !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h/%h expected 0", rd_re, rd_im); end
    rd_addr = 5'd17; @(posedge clk); #1;
    checks++;
    if ({rd_re, rd_im} !== 32'd0) begin errors++; $display("FAIL reset_buffer: got %h/%h expected 0", rd_re, rd_im); end
  endtask

  task automatic test_impulse();
    hold_hi = 0; lat = 4;
    for (int i = 0; i < N; i++) begin in_re[i] = '0; in_im[i] = '0; end
    in_re[0] = 16'h0200;
    run_and_check("impulse", 1'b0, 1'b0);
  endtask

  task automatic test_dc();
    logic [DW-1:0] want0;
    want0 = SCALE ? 16'h0200 : 16'h4000;
    hold_hi = 0; lat = 4;
    for (int i = 0; i < N; i++) begin in_re[i] = 16'h0200; in_im[i] = '0; end
    run_and_check("dc", 1'b0, 1'b0);
    rd_addr = 5'd0; @(posedge clk); #1;
    checks++;
    if (rd_re !== want0) begin errors++; $display("FAIL dc_bin0: got %h expected %h", rd_re, want0); end
  endtask

  task automatic test_stale_ready();
    int s0;
    s0 = stab_err;
    hold_hi = 3; lat = 10;
    for (int i = 0; i < N; i++) begin in_re[i] = 16'($urandom); in_im[i] = 16'($urandom); end
    run_and_check("stale_ready", 1'b0, 1'b1);
    checks++;
    if (stab_err != s0) begin errors++; $display("FAIL operand_stability: got %0d changes expected 0", stab_err - s0); end
  endtask

  task automatic test_twiddle();
    int b, want;
    hold_hi = 0; lat = 1;
    for (int i = 0; i < N; i++) begin in_re[i] = 16'($urandom); in_im[i] = 16'($urandom); end
    b = tw_log.size();
    run_and_check("twiddle_run", 1'b0, 1'b1);
    checks++;
    if (tw_log.size() - b != 80) begin errors++; $display("FAIL twiddle_count: got %0d expected 80", tw_log.size() - b); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (tw_log[b + i] != 0) begin errors++; $display("FAIL tw_stage0[%0d]: got %0d expected 0", i, tw_log[b + i]); end
        want = (i % 4) * 4;
        checks++;
        if (tw_log[b + 32 + i] != want) begin errors++; $display("FAIL tw_stage2[%0d]: got %0d expected %0d", i, tw_log[b + 32 + i], want); end
        checks++;
        if (tw_log[b + 64 + i] != i) begin errors++; $display("FAIL tw_stage4[%0d]: got %0d expected %0d", i, tw_log[b + 64 + i], i); end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      hold_hi = $urandom_range(0, 2); lat = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) begin in_re[i] = 16'($urandom); in_im[i] = 16'($urandom); end
      run_and_check($sformatf("random%0d", r), 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset_mid_wait();
    int t0, cyc, d0;
    hold_hi = 0; lat = 6;
    for (int i = 0; i < N; i++) begin in_re[i] = 16'($urandom); in_im[i] = 16'($urandom); end
    t0 = toggles; d0 = done_cnt;
    load_and_start(5, 1);
    cyc = 0;
    while (cyc < 2000 && !(toggles - t0 >= 5 && bf_ready_flag === 1'b0)) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc >= 2000) begin errors++; $display("FAIL midwait_reach: got timeout expected WAIT within 2000 cycles"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, bf_new_input_flag} !== 3'b000) begin
      errors++; $display("FAIL midwait_status: got busy=%b done=%b flag=%b expected 0", busy, done, bf_new_input_flag);
    end
    checks++;
    if ({bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle_num, rd_re, rd_im} !== 100'd0) begin
      errors++; $display("FAIL midwait_outputs: got %h %h %h %h tw=%h rd=%h/%h expected 0",
                        bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle_num, rd_re, rd_im);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_addr = 5'd9; @(posedge clk); #1;
    checks++;
    if ({rd_re, rd_im} !== 32'd0) begin errors++; $display("FAIL midwait_buffer: got %h/%h expected 0", rd_re, rd_im); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL midwait_no_done: got %0d pulses expected 0", done_cnt - d0); end
    run_and_check("restart", 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_stale_ready();
    test_twiddle();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
